// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC fetch unit.
// No logic here; imported by the fetch FSM and the next-PC selector.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        TRAP  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC mux and alignment check; purely combinational, zero latency.
// No flow control: the caller decides when the result is consumed.
module next_pc_sel
    import pc_fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        sel_i,
    input  logic [31:0] target_i,
    output logic [31:0] next_pc_o,
    output logic        misaligned_o
);

    // The 32-bit add wraps naturally at 2^32.
    assign next_pc_o    = sel_i ? target_i : (pc_i + PC_INC);
    assign misaligned_o = (next_pc_o[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch FSM: issues imem reads at PC, holds the word until decode accepts it; 1-cycle ready->valid.
// Backpressure: Inst/PC are frozen in HOLD until inst_valid && inst_ready; a misaligned next PC traps.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        NextPCSrc,
    input  logic [31:0] ALURes,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] Inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        misaligned,
    output logic [31:0] retired_cnt,
    output logic [31:0] taken_cnt
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  inst_q;
    logic         inst_valid_q;
    logic         imem_req_q;
    logic         misaligned_q;
    logic [31:0]  retired_q;
    logic [31:0]  taken_q;

    logic [31:0]  next_pc_d;
    logic         next_misaligned_d;
    logic         accept;

    next_pc_sel u_next_pc_sel (
        .pc_i         (pc_q),
        .sel_i        (NextPCSrc),
        .target_i     (ALURes),
        .next_pc_o    (next_pc_d),
        .misaligned_o (next_misaligned_d)
    );

    assign accept = inst_valid_q && inst_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0;
            inst_valid_q <= 1'b0;
            imem_req_q   <= 1'b0;
            misaligned_q <= 1'b0;
            retired_q    <= 32'h0;
            taken_q      <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q    <= FETCH;
                    imem_req_q <= 1'b1;
                end
                FETCH: begin
                    if (imem_ready) begin
                        inst_q       <= imem_rdata;
                        inst_valid_q <= 1'b1;
                        imem_req_q   <= 1'b0;
                        state_q      <= HOLD;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        inst_valid_q <= 1'b0;
                        retired_q    <= retired_q + 32'd1;
                        // A faulting target keeps PC on the instruction that produced it.
                        if (next_misaligned_d) begin
                            misaligned_q <= 1'b1;
                            state_q      <= TRAP;
                        end else begin
                            pc_q       <= next_pc_d;
                            taken_q    <= taken_q + {31'h0, NextPCSrc};
                            imem_req_q <= 1'b1;
                            state_q    <= FETCH;
                        end
                    end
                end
                TRAP: begin
                    state_q <= TRAP;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign PC          = pc_q;
    assign Inst        = inst_q;
    assign inst_valid  = inst_valid_q;
    assign misaligned  = misaligned_q;
    assign retired_cnt = retired_q;
    assign taken_cnt   = taken_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: inputs change on the falling edge, outputs are checked there too.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        NextPCSrc;
    logic [31:0] ALURes;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [31:0] Inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        misaligned;
    logic [31:0] retired_cnt;
    logic [31:0] taken_cnt;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .NextPCSrc   (NextPCSrc),
        .ALURes      (ALURes),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .PC          (PC),
        .Inst        (Inst),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .misaligned  (misaligned),
        .retired_cnt (retired_cnt),
        .taken_cnt   (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".imem_req"},    {31'h0, imem_req},   32'h0);
        chk({tag, ".PC"},          PC,                  32'h0);
        chk({tag, ".Inst"},        Inst,                32'h0);
        chk({tag, ".inst_valid"},  {31'h0, inst_valid}, 32'h0);
        chk({tag, ".misaligned"},  {31'h0, misaligned}, 32'h0);
        chk({tag, ".retired_cnt"}, retired_cnt,         32'h0);
        chk({tag, ".taken_cnt"},   taken_cnt,           32'h0);
    endtask

    // Called at a falling edge while in FETCH; returns at the falling edge after the word is held.
    task automatic do_fetch(input logic [31:0] rdata, input logic [31:0] exp_addr);
        chk("fetch.imem_req", {31'h0, imem_req}, 32'h1);
        chk("fetch.imem_addr", imem_addr, exp_addr);
        imem_ready = 1'b1;
        imem_rdata = rdata;
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rdata = 32'hBAD0_BAD0;
        chk("fetch.inst_valid", {31'h0, inst_valid}, 32'h1);
        chk("fetch.Inst", Inst, rdata);
        chk("fetch.req_low", {31'h0, imem_req}, 32'h0);
    endtask

    // Called at a falling edge while in HOLD; one-cycle accept.
    task automatic do_accept(input logic src, input logic [31:0] tgt);
        inst_ready = 1'b1;
        NextPCSrc  = src;
        ALURes     = tgt;
        @(negedge clk);
        inst_ready = 1'b0;
        NextPCSrc  = 1'b1;
        ALURes     = 32'h0000_0003;
        chk("accept.inst_valid", {31'h0, inst_valid}, 32'h0);
    endtask

    initial begin
        rst_n      = 1'b0;
        NextPCSrc  = 1'b0;
        ALURes     = 32'h0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        inst_ready = 1'b0;

        @(negedge clk);
        @(negedge clk);
        chk_reset("reset");

        rst_n = 1'b1;
        @(negedge clk);
        // IDLE -> FETCH, first fetch at RESET_PC
        do_fetch(32'h0000_0013, 32'h0);

        do_accept(1'b1, 32'h0000_0010);
        chk("jmp10.PC", PC, 32'h10);
        chk("jmp10.retired", retired_cnt, 32'd1);
        chk("jmp10.taken", taken_cnt, 32'd1);

        do_fetch(32'h0000_00AA, 32'h10);
        do_accept(1'b0, 32'hFFFF_FFF0);
        chk("seq14.PC", PC, 32'h14);
        chk("seq14.retired", retired_cnt, 32'd2);
        chk("seq14.taken", taken_cnt, 32'd1);

        do_fetch(32'h0000_00BB, 32'h14);
        do_accept(1'b1, 32'h0000_0100);
        chk("jmp100.PC", PC, 32'h100);
        chk("jmp100.retired", retired_cnt, 32'd3);
        chk("jmp100.taken", taken_cnt, 32'd2);

        do_fetch(32'h0000_00CC, 32'h100);
        do_accept(1'b1, 32'hFFFF_FFFC);
        chk("jmptop.PC", PC, 32'hFFFF_FFFC);
        do_fetch(32'h0000_00DD, 32'hFFFF_FFFC);
        do_accept(1'b0, 32'h0000_0040);
        chk("wrap.PC", PC, 32'h0);
        chk("wrap.retired", retired_cnt, 32'd5);
        chk("wrap.taken", taken_cnt, 32'd3);

        // inst_ready with no valid instruction must do nothing
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        chk("noval.retired", retired_cnt, 32'd5);
        chk("noval.PC", PC, 32'h0);

        // Memory stalls five cycles
        for (int i = 0; i < 5; i++) begin
            chk("stall.imem_req", {31'h0, imem_req}, 32'h1);
            chk("stall.inst_valid", {31'h0, inst_valid}, 32'h0);
            @(negedge clk);
        end
        do_fetch(32'hDEAD_BEEF, 32'h0);

        // Decode stalls three cycles; stray imem_ready must be ignored
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_0055;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold.Inst", Inst, 32'hDEAD_BEEF);
            chk("hold.inst_valid", {31'h0, inst_valid}, 32'h1);
            chk("hold.PC", PC, 32'h0);
        end
        imem_ready = 1'b0;

        // Misaligned branch target
        do_accept(1'b1, 32'h0000_0102);
        chk("mis.flag", {31'h0, misaligned}, 32'h1);
        chk("mis.PC", PC, 32'h0);
        chk("mis.retired", retired_cnt, 32'd6);
        chk("mis.taken", taken_cnt, 32'd3);

        // TRAP absorbs everything
        imem_ready = 1'b1;
        inst_ready = 1'b1;
        ALURes     = 32'h0000_0200;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("trap.imem_req", {31'h0, imem_req}, 32'h0);
        end
        imem_ready = 1'b0;
        inst_ready = 1'b0;
        chk("trap.flag", {31'h0, misaligned}, 32'h1);
        chk("trap.retired", retired_cnt, 32'd6);
        chk("trap.PC", PC, 32'h0);

        // Reset out of TRAP
        rst_n = 1'b0;
        #1;
        chk_reset("trapreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while FETCH has imem_ready pending: the word is dropped
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_0077;
        #1;
        rst_n = 1'b0;
        #1;
        chk("fetchrst.imem_req", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        imem_ready = 1'b0;
        rst_n      = 1'b1;
        chk("fetchrst.Inst", Inst, 32'h0);
        chk("fetchrst.inst_valid", {31'h0, inst_valid}, 32'h0);

        // Reset pulse mid-HOLD
        @(negedge clk);
        do_fetch(32'h0000_0033, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("holdrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after.imem_req", {31'h0, imem_req}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 NextPCSrc  input  1  branch-unit decision: 1 = take target, 0 = sequential; sampled only in an accept cycle.
REQ-005 ALURes  input  32  branch/jump target address; sampled only in an accept cycle.
REQ-006 imem_req  output  1  instruction-memory read request.
REQ-007 imem_addr  output  32  word address of the request; equals PC.
REQ-008 imem_ready  input  1  memory has imem_rdata valid this cycle.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 PC  output  32  address of the instruction currently fetched or held.
REQ-011 Inst  output  32  held instruction to decode.
REQ-012 inst_valid  output  1  Inst is valid.
REQ-013 inst_ready  input  1  decode/execute consumes Inst; accept = inst_valid && inst_ready.
REQ-014 misaligned  output  1  sticky instruction-address-misaligned trap flag.
REQ-015 retired_cnt  output  32  count of accepted instructions.
REQ-016 taken_cnt  output  32  count of accepts with NextPCSrc=1.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, HOLD, TRAP; IDLE SHALL go to FETCH unconditionally on the next edge.
REQ-018 In FETCH, imem_req SHALL be 1; in all other states it SHALL be 0.
REQ-019 In FETCH with imem_ready=1, Inst SHALL load imem_rdata, inst_valid SHALL rise on the next edge, and the FSM SHALL go to HOLD (ready in cycle n -> inst_valid in cycle n+1).
REQ-020 imem_ready outside FETCH SHALL be ignored.
REQ-021 In HOLD, Inst and PC SHALL remain stable until accept.
REQ-022 On accept, next = NextPCSrc ? ALURes : PC+4, with PC+4 computed modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 On accept with next[1:0]==2'b00, PC SHALL load next, inst_valid SHALL clear, retired_cnt SHALL increment, taken_cnt SHALL increment if NextPCSrc=1, and the FSM SHALL go to FETCH.
REQ-024 On accept with next[1:0]!=2'b00, the FSM SHALL go to TRAP, misaligned SHALL set, and PC SHALL hold the faulting instruction's address.
REQ-025 In the same accept, retired_cnt SHALL increment while taken_cnt SHALL NOT, and inst_valid SHALL clear.
REQ-026 TRAP SHALL be absorbing until rst_n; all inputs are ignored there.
REQ-027 Both counters SHALL wrap from 32'hFFFF_FFFF to 0 without side effects.
REQ-028 inst_ready without inst_valid SHALL have no effect.

Reset
REQ-029 While rst_n=0: state=IDLE, PC=RESET_PC, imem_req=0, Inst=0, inst_valid=0, misaligned=0, retired_cnt=0, taken_cnt=0, asynchronously.
REQ-030 Reset asserted mid-FETCH or mid-HOLD SHALL drop imem_req and inst_valid immediately; a pending imem_ready SHALL be discarded.

Structure
REQ-031 Package pc_fetch_pkg SHALL hold the state enum, the default RESET_PC value, and the PC_INC constant (4).
REQ-032 Next-PC selection and the alignment check SHALL live in one combinational sub-module, next_pc_sel.

Verification
REQ-033 Reset release, imem_ready=1 on the first FETCH cycle, rdata=32'h0000_0013 -> imem_addr=0; Inst=32'h13 and inst_valid=1 one cycle later.
REQ-034 Accept with NextPCSrc=0, PC=32'h10 -> PC=32'h14, retired_cnt+1, taken_cnt unchanged.
REQ-035 Accept with NextPCSrc=1, ALURes=32'h100 -> PC=32'h100, taken_cnt+1.
REQ-036 Accept with NextPCSrc=1, ALURes=32'h102 -> misaligned=1 and PC unchanged, then imem_req stays 0 for 20 cycles.
REQ-037 PC=32'hFFFF_FFFC, accept with NextPCSrc=0 -> PC=0.
REQ-038 imem_ready held low 5 cycles in FETCH and inst_ready held low 3 cycles in HOLD -> Inst stable throughout; rst_n pulsed in HOLD -> all outputs return to reset values immediately.
